// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op codes, controller states and the op-code type.
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD = 3'd0;
    localparam op_t OP_SUB = 3'd1;
    localparam op_t OP_DIV = 3'd2;
    localparam op_t OP_AND = 3'd3;
    localparam op_t OP_XOR = 3'd4;
    localparam op_t OP_OR  = 3'd5;
    localparam op_t OP_NOR = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant; last_grant only advances when the granted request is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant,
    output logic       grant_valid
);

    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    always_comb begin
        grant_valid = |valid;
        grant       = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional macro ALU_ARB_DIVZ_TRAP_EN: divide-by-zero bypasses the ALU and flags rsp_divz.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch,
    output logic             rsp_divz
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_t              op;
    } req_t;

    state_t        state, state_next;
    req_t          req_sel, op_q;
    logic          id_q;
    logic [CW-1:0] count;
    logic          grant, grant_valid, accept, trap;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       ({req1_valid, req0_valid}),
        .accept      (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // rst_n gates the handshake so ready stays low while reset is held
    assign accept     = rst_n && (state == IDLE) && grant_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        req_sel = '{a: req0_a, b: req0_b, op: req0_op};
        if (grant) begin
            req_sel = '{a: req1_a, b: req1_b, op: req1_op};
        end
    end

`ifdef ALU_ARB_DIVZ_TRAP_EN
    logic divz_q;
    assign trap     = (req_sel.op == OP_DIV) && (req_sel.b == '0);
    assign rsp_divz = divz_q;
`else
    assign trap     = 1'b0;
    assign rsp_divz = 1'b0;
`endif

    assign alu_a     = op_q.a;
    assign alu_b     = op_q.b;
    assign alu_op    = op_q.op;
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = trap ? RESP : EXEC;
            EXEC: if (count == '0) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand registers change only on a non-trapped accept, so the ALU inputs never toggle elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            id_q       <= 1'b0;
            count      <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
`ifdef ALU_ARB_DIVZ_TRAP_EN
            divz_q     <= 1'b0;
`endif
        end else if (accept) begin
            id_q <= grant;
            if (!trap) begin
                op_q  <= req_sel;
                count <= (req_sel.op == OP_DIV) ? CW'(DIV_CYCLES - 1) : '0;
            end
`ifdef ALU_ARB_DIVZ_TRAP_EN
            else begin
                rsp_id     <= grant;
                rsp_result <= '0;
                rsp_branch <= (req_sel.a == '0);
                divz_q     <= 1'b1;
            end
`endif
        end else if (state == EXEC) begin
            if (count == '0) begin
                rsp_id     <= id_q;
                rsp_result <= alu_result;
                rsp_branch <= alu_branch;
`ifdef ALU_ARB_DIVZ_TRAP_EN
                divz_q     <= 1'b0;
`endif
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W    = 32;
    localparam int DIVC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         alu_branch;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_branch, rsp_divz;
    logic [W-1:0] rsp_result;

    alu_arbiter #(.WIDTH(W), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_branch(rsp_branch), .rsp_divz(rsp_divz)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] refAlu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return (b == '0) ? '1 : a / b;
            3'd3: return a & b;
            3'd4: return a ^ b;
            3'd5: return a | b;
            3'd6: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // The ALU the controller drives; divide by zero returns all ones here
    always_comb begin
        alu_result = refAlu(alu_a, alu_b, alu_op);
        alu_branch = (alu_a == alu_b);
    end

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; } op_s;
    typedef struct { logic id; logic [W-1:0] result; logic branch; logic divz; } rsp_s;

    op_s  q0[$], q1[$];
    rsp_s log_q[$];
    int   errors = 0, checks = 0, cyc = 0;
    bit   busy = 0, last = 1, hold_ok = 0, acc0 = 0, acc1 = 0, rand_mode = 0;
    int   rr_mode = 1, acc_cyc = 0, lat = 0;
    rsp_s exp_rsp;
    logic [W-1:0] hold_a, hold_b;
    logic [2:0]   hold_op;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic applyStimulus();
        if (acc0 && q0.size() > 0) q0.delete(0);
        if (acc1 && q1.size() > 0) q1.delete(0);
        req0_valid = (q0.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        req1_valid = (q1.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op; end
        if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op; end
        rsp_ready = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        applyStimulus();
    end

    // Transaction model: one op in flight, round-robin on conflict, fixed latency per op class
    always @(negedge clk) begin : monitor
        logic e0, e1, tr;
        op_s  o;
        acc0 = 0;
        acc1 = 0;
        if (!rst_n) begin
            busy    = 0;
            last    = 1;
            hold_ok = 0;
        end else begin
            e0 = !busy && req0_valid && (!req1_valid || last);
            e1 = !busy && req1_valid && (!req0_valid || !last);
            checkOutput("req0_ready", req0_ready, e0);
            checkOutput("req1_ready", req1_ready, e1);
            if (hold_ok) begin
                checkOutput("alu_a_hold", alu_a, hold_a);
                checkOutput("alu_b_hold", alu_b, hold_b);
                checkOutput("alu_op_hold", alu_op, hold_op);
            end
            if (busy) begin
                checkOutput("rsp_valid", rsp_valid, (cyc - acc_cyc) >= lat);
                if (rsp_valid && (cyc - acc_cyc) >= lat) begin
                    checkOutput("rsp_id", rsp_id, exp_rsp.id);
                    checkOutput("rsp_result", rsp_result, exp_rsp.result);
                    checkOutput("rsp_branch", rsp_branch, exp_rsp.branch);
                    checkOutput("rsp_divz", rsp_divz, exp_rsp.divz);
                    if (rsp_ready) begin
                        log_q.push_back('{rsp_id, rsp_result, rsp_branch, rsp_divz});
                        busy = 0;
                    end
                end
            end else begin
                checkOutput("rsp_valid_idle", rsp_valid, 1'b0);
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc0 = req0_valid && req0_ready;
                acc1 = !acc0;
                o = acc0 ? '{req0_a, req0_b, req0_op} : '{req1_a, req1_b, req1_op};
                last = acc1;
                tr = 0;
`ifdef ALU_ARB_DIVZ_TRAP_EN
                tr = (o.op == 3'd2) && (o.b == '0);
`endif
                if (tr) begin
                    exp_rsp = '{acc1, '0, (o.a == '0), 1'b1};
                    lat = 1;
                end else begin
                    exp_rsp = '{acc1, refAlu(o.a, o.b, o.op), (o.a == o.b), 1'b0};
                    lat = (o.op == 3'd2) ? 1 + DIVC : 2;
                    hold_ok = 1;
                    hold_a  = o.a;
                    hold_b  = o.b;
                    hold_op = o.op;
                end
                busy    = 1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req0_ready"}, req0_ready, 0);
        checkOutput({tag, "_req1_ready"}, req1_ready, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_id"}, rsp_id, 0);
        checkOutput({tag, "_rsp_result"}, rsp_result, 0);
        checkOutput({tag, "_rsp_branch"}, rsp_branch, 0);
        checkOutput({tag, "_rsp_divz"}, rsp_divz, 0);
        checkOutput({tag, "_alu_a"}, alu_a, 0);
        checkOutput({tag, "_alu_b"}, alu_b, 0);
        checkOutput({tag, "_alu_op"}, alu_op, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 checkResetOutputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic waitLog(input string tag, input int n);
        for (int i = 0; i < 200 && log_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput(tag, log_q.size(), n);
    endtask

    function automatic op_s genOp();
        op_s o;
        o.op = 3'($urandom_range(0, 7));
        o.a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        case ($urandom_range(0, 5))
            0: o.b = '0;
            1: o.b = o.a;
            2: o.b = W'($urandom_range(1, 15));
            default: o.b = W'($urandom);
        endcase
        return o;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        // Single add from requester 0
        @(negedge clk);
        log_q.delete();
        q0.push_back('{32'd5, 32'd7, OP_ADD});
        waitLog("add_done", 1);
        checkOutput("add_result", log_q[0].result, 12);
        checkOutput("add_id", log_q[0].id, 0);
        checkOutput("add_branch", log_q[0].branch, 0);

        // Conflicts right after reset: requester 0 first, then strict alternation
        doReset();
        @(negedge clk);
        log_q.delete();
        q0.push_back('{32'd10, 32'd3, OP_SUB});
        q1.push_back('{32'hF0, 32'h3C, OP_AND});
        waitLog("conflict_done", 2);
        checkOutput("sub_result", log_q[0].result, 7);
        checkOutput("sub_id", log_q[0].id, 0);
        checkOutput("and_result", log_q[1].result, 32'h30);
        checkOutput("and_id", log_q[1].id, 1);
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{W'(i), W'(1), OP_OR});
            q1.push_back('{W'(i), W'(2), OP_XOR});
        end
        waitLog("alt_done", 6);
        for (int i = 2; i < 6; i++) checkOutput($sformatf("alt_id%0d", i), log_q[i].id, (i % 2));

        // Multicycle divide
        @(negedge clk);
        log_q.delete();
        q0.push_back('{32'd100, 32'd7, OP_DIV});
        waitLog("div_done", 1);
        checkOutput("div_result", log_q[0].result, 14);

        // Response back-pressure with another request waiting
        rr_mode = 0;
        @(negedge clk);
        log_q.delete();
        q1.push_back('{32'hDEADBEEE, 32'd1, OP_ADD});
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        q0.push_back('{32'd1, 32'd2, OP_ADD});
        repeat (6) @(negedge clk);
        #1 checkOutput("held_valid", rsp_valid, 1);
        checkOutput("held_result", rsp_result, 32'hDEADBEEF);
        checkOutput("held_no_rsp", log_q.size(), 0);
        rr_mode = 1;
        waitLog("held_done", 2);
        checkOutput("held_log_result", log_q[0].result, 32'hDEADBEEF);
        checkOutput("held_log_id", log_q[0].id, 1);
        checkOutput("next_result", log_q[1].result, 3);
        checkOutput("next_id", log_q[1].id, 0);

        // Reset in the middle of a divide
        @(negedge clk);
        log_q.delete();
        q0.push_back('{32'd1000, 32'd3, OP_DIV});
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1 checkOutput("abort_no_rsp", log_q.size(), 0);
        q1.push_back('{32'd6, 32'd6, OP_XOR});
        waitLog("post_reset_done", 1);
        checkOutput("post_reset_result", log_q[0].result, 0);
        checkOutput("post_reset_branch", log_q[0].branch, 1);

        // Divide by zero
        @(negedge clk);
        log_q.delete();
        q0.push_back('{32'd9, 32'd0, OP_DIV});
        waitLog("divz_done", 1);
`ifdef ALU_ARB_DIVZ_TRAP_EN
        checkOutput("divz_result", log_q[0].result, 0);
        checkOutput("divz_flag", log_q[0].divz, 1);
        checkOutput("divz_branch", log_q[0].branch, 0);
`else
        checkOutput("divz_result", log_q[0].result, 32'hFFFFFFFF);
        checkOutput("divz_flag", log_q[0].divz, 0);
`endif

        // Randomized traffic with random back-pressure and valid drops
        rand_mode = 1;
        rr_mode   = 2;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(genOp());
            if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(genOp());
        end
        rand_mode = 0;
        rr_mode   = 1;
        for (int i = 0; i < 2000 && (q0.size() + q1.size() + int'(busy)) != 0; i++) @(negedge clk);
        #1 checkOutput("drain", q0.size() + q1.size() + int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU datapath (ops 0 add, 1 sub, 2 div, 3 and, 4 xor, 5 or, 6 nor, other codes give 0, plus A==B branch flag) between two requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the operands, holds them stable while the ALU evaluates, and returns the result through a valid/ready response channel.
- The divide op is treated as a multicycle path and held for DIV_CYCLES cycles.

Parameters:
- WIDTH, 32, operand/result width.
- DIV_CYCLES, 4, cycles operands are held for op 2 (divide); legal range >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  WIDTH  operand A, requester 0.
- req0_b  input  WIDTH  operand B, requester 0.
- req0_op  input  3  ALU control code, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  3  to ALU control signal.
- alu_result  input  WIDTH  from ALU result.
- alu_branch  input  1  from ALU branch (A==B).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester that issued the op.
- rsp_result  output  WIDTH  captured result.
- rsp_branch  output  1  captured branch flag.
- rsp_divz  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): state IDLE, last_grant=1, all outputs 0 (req*_ready, rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_divz, alu_a, alu_b, alu_op). Reset mid-operation aborts the op silently; no response is produced.
- States:
  - IDLE: req_ready asserted combinationally only to the granted requester.
    - Grant = the sole valid requester.
    - If both are valid, grant goes to the requester != last_grant.
    - On handshake: capture a, b, op, id into registers; last_grant<=id; count<=(op==2 ? DIV_CYCLES-1 : 0); go to EXEC.
  - EXEC: alu_a/b/op driven from the operand registers (held constant). If count==0, capture alu_result and alu_branch into the rsp registers and go to RESP; else count decrements.
  - RESP: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE (rsp_valid low next cycle).
- No request is accepted in EXEC or RESP; req*_ready=0 there.
- Latency from accept edge N:
  - Non-divide: rsp_valid rises after edge N+2.
  - Divide: rsp_valid rises after edge N+1+DIV_CYCLES.
  - Best-case issue rate for non-divide ops: one per 3 cycles with rsp_ready held high.
- alu_a/alu_b/alu_op keep their last values outside EXEC (no toggling).
- Op codes 7 and other unused codes are passed through unchanged; the controller does not interpret the result.
- Request valid deasserting without handshake is legal. Stability of payload while valid and not ready is not required, because capture happens only at handshake.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro ALU_ARB_DIVZ_TRAP_EN.
- Defined:
  - In IDLE, an accepted op==2 with b==0 skips EXEC.
  - rsp_result=0, rsp_branch=(a==0), rsp_divz=1; go directly to RESP.
  - rsp_valid rises after edge N+1.
- Undefined:
  - Divide by zero is issued normally, and the ALU output is returned as-is (undefined value).
  - rsp_divz is tied 0.

Decomposition:
- Package alu_pkg:
  - ALU op-code localparams (OP_ADD=0 … OP_NOR=6).
  - state enum typedef {IDLE, EXEC, RESP}.
  - Request struct {a, b, op}.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant with a last_grant register and an update-on-accept input.

Test Plan:
- Req0 add a=5, b=7 alone, rsp_ready=1 -> req0_ready pulses 1 cycle; rsp_valid 2 cycles later with result 12, id 0, branch 0.
- Both valid from reset: req0 sub 10-3, req1 and 0xF0&0x3C -> req0 served first (result 7), then req1 (result 0x30); two back-to-back conflicts alternate grants.
- Div 100/7 with DIV_CYCLES=4 -> alu_a/b/op stable for 4 EXEC cycles; result 14; rsp_valid 5 cycles after accept.
- rsp_ready held 0 for 6 cycles with result 0xDEADBEEF -> response held stable, no new accept; single grant follows release.
- rst_n low during a divide EXEC cycle -> outputs 0 immediately; no response after release; next request completes normally.
- With ALU_ARB_DIVZ_TRAP_EN, div 9/0 -> rsp_valid 1 cycle after accept, result 0, rsp_divz 1; without the macro, rsp_divz stays 0.
